// File: rtl/io_bus_arbiter.sv
// io_bus_arbiter: shares one I/O device port among NUM_CH cores, one transaction at a time,
// round-robin, with an optional device-ack timeout that answers the core with an error.
module io_bus_arbiter #(
   parameter int NUM_CH   = 2,
   parameter int D_WIDTH  = 34,
   parameter int PA_WIDTH = 4,
   parameter int TIMEOUT  = 16
) (
   input  logic                         clk,
   input  logic                         reset_n_i,
   input  logic [NUM_CH-1:0]            ch_read_req_i,
   input  logic [NUM_CH-1:0]            ch_write_req_i,
   input  logic [NUM_CH*PA_WIDTH-1:0]   ch_read_addr_i,
   input  logic [NUM_CH*PA_WIDTH-1:0]   ch_write_addr_i,
   input  logic [NUM_CH*D_WIDTH-1:0]    ch_wdata_i,
   output logic [D_WIDTH-1:0]           ch_rdata_o,
   output logic [NUM_CH-1:0]            ch_read_ack_o,
   output logic [NUM_CH-1:0]            ch_write_ack_o,
   output logic [NUM_CH-1:0]            ch_err_o,
   output logic                         dev_read_req_o,
   output logic                         dev_write_req_o,
   output logic [PA_WIDTH-1:0]          dev_read_addr_o,
   output logic [PA_WIDTH-1:0]          dev_write_addr_o,
   output logic [D_WIDTH-1:0]           dev_wdata_o,
   input  logic [D_WIDTH-1:0]           dev_rdata_i,
   input  logic                         dev_read_ack_i,
   input  logic                         dev_write_ack_i
);

   localparam int IDX_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam int TMO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TMO_LAST);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_CH - 1);
   localparam logic             TMO_EN   = (TIMEOUT != 0) ? 1'b1 : 1'b0;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic [IDX_W-1:0]      r_gnt;
   logic                  r_dir_rd;
   logic [PA_WIDTH-1:0]   r_addr;
   logic [D_WIDTH-1:0]    r_wdata;
   logic [IDX_W-1:0]      r_rr_ptr;
   logic [CNT_W-1:0]      r_cnt;

   logic                  r_dev_read_req;
   logic                  r_dev_write_req;
   logic [PA_WIDTH-1:0]   r_dev_read_addr;
   logic [PA_WIDTH-1:0]   r_dev_write_addr;
   logic [D_WIDTH-1:0]    r_dev_wdata;
   logic [NUM_CH-1:0]     r_ch_read_ack;
   logic [NUM_CH-1:0]     r_ch_write_ack;
   logic [NUM_CH-1:0]     r_ch_err;
   logic [D_WIDTH-1:0]    r_ch_rdata;

   logic                  w_any;
   logic                  w_hit;
   logic [IDX_W:0]        w_cand;
   logic [IDX_W-1:0]      w_sel;
   logic                  w_sel_rd;
   logic [PA_WIDTH-1:0]   w_sel_raddr;
   logic [PA_WIDTH-1:0]   w_sel_waddr;
   logic [D_WIDTH-1:0]    w_sel_wdata;
   logic                  w_dev_ack;
   logic                  w_tmo;
   logic [IDX_W-1:0]      w_rr_nxt;
   logic [NUM_CH-1:0]     w_gnt_mask;

   logic                  w_dev_read_req_nxt;
   logic                  w_dev_write_req_nxt;
   logic [PA_WIDTH-1:0]   w_dev_read_addr_nxt;
   logic [PA_WIDTH-1:0]   w_dev_write_addr_nxt;
   logic [D_WIDTH-1:0]    w_dev_wdata_nxt;
   logic [NUM_CH-1:0]     w_ch_read_ack_nxt;
   logic [NUM_CH-1:0]     w_ch_write_ack_nxt;
   logic [NUM_CH-1:0]     w_ch_err_nxt;
   logic [D_WIDTH-1:0]    w_ch_rdata_nxt;

   // Round-robin search: first requesting channel at or after rr_ptr, wrapping.
   always_comb begin
      w_any  = 1'b0;
      w_hit  = 1'b0;
      w_sel  = '0;
      w_cand = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         w_cand = {1'b0, r_rr_ptr} + (IDX_W+1)'(i);
         w_cand = (w_cand >= (IDX_W+1)'(NUM_CH)) ? (w_cand - (IDX_W+1)'(NUM_CH)) : w_cand;
         w_hit  = !w_any && (ch_read_req_i[w_cand[IDX_W-1:0]] || ch_write_req_i[w_cand[IDX_W-1:0]]);
         w_sel  = w_hit ? w_cand[IDX_W-1:0] : w_sel;
         w_any  = w_any | w_hit;
      end
   end

   // Read wins when a channel raises both directions; the write stays pending.
   assign w_sel_rd    = ch_read_req_i[w_sel];
   assign w_sel_raddr = ch_read_addr_i[int'(w_sel)*PA_WIDTH +: PA_WIDTH];
   assign w_sel_waddr = ch_write_addr_i[int'(w_sel)*PA_WIDTH +: PA_WIDTH];
   assign w_sel_wdata = ch_wdata_i[int'(w_sel)*D_WIDTH +: D_WIDTH];

   assign w_dev_ack  = r_dir_rd ? dev_read_ack_i : dev_write_ack_i;
   assign w_tmo      = TMO_EN && (r_cnt == CNT_LAST);
   assign w_rr_nxt   = (r_gnt == IDX_LAST) ? '0 : (r_gnt + IDX_W'(1));
   assign w_gnt_mask = NUM_CH'(1) << r_gnt;

   // State register plus the per-transaction latches, counter and rr pointer.
   always_ff @(posedge clk or negedge reset_n_i) begin
      if (!reset_n_i) begin
         r_state  <= ST_IDLE;
         r_gnt    <= '0;
         r_dir_rd <= 1'b0;
         r_addr   <= '0;
         r_wdata  <= '0;
         r_rr_ptr <= '0;
         r_cnt    <= '0;
      end else begin
         r_state <= w_state_nxt;
         case (r_state)
            ST_IDLE: begin
               r_cnt <= '0;
               if (w_any) begin
                  r_gnt    <= w_sel;
                  r_dir_rd <= w_sel_rd;
                  r_addr   <= w_sel_rd ? w_sel_raddr : w_sel_waddr;
                  r_wdata  <= w_sel_rd ? '0 : w_sel_wdata;
               end else begin
                  r_gnt <= r_gnt;
               end
            end
            ST_BUSY: r_cnt <= r_cnt + CNT_W'(1);
            ST_RESP: begin
               r_cnt    <= '0;
               r_rr_ptr <= w_rr_nxt;
            end
            default: r_cnt <= '0;
         endcase
      end
   end

   // Next-state logic; an ack in the final timeout cycle beats the timeout.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: w_state_nxt = w_any ? ST_BUSY : ST_IDLE;
         ST_BUSY: begin
            if (w_dev_ack || w_tmo) begin
               w_state_nxt = ST_RESP;
            end else begin
               w_state_nxt = ST_BUSY;
            end
         end
         ST_RESP: w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Next values of the registered outputs, derived from the transition being taken.
   always_comb begin
      w_dev_read_req_nxt   = 1'b0;
      w_dev_write_req_nxt  = 1'b0;
      w_dev_read_addr_nxt  = '0;
      w_dev_write_addr_nxt = '0;
      w_dev_wdata_nxt      = '0;
      w_ch_read_ack_nxt    = '0;
      w_ch_write_ack_nxt   = '0;
      w_ch_err_nxt         = '0;
      w_ch_rdata_nxt       = r_ch_rdata;
      case (r_state)
         ST_IDLE: begin
            if (w_any) begin
               w_dev_read_req_nxt   = w_sel_rd;
               w_dev_write_req_nxt  = !w_sel_rd;
               w_dev_read_addr_nxt  = w_sel_rd ? w_sel_raddr : '0;
               w_dev_write_addr_nxt = w_sel_rd ? '0 : w_sel_waddr;
               w_dev_wdata_nxt      = w_sel_rd ? '0 : w_sel_wdata;
            end else begin
               w_ch_rdata_nxt = r_ch_rdata;
            end
         end
         ST_BUSY: begin
            if (w_state_nxt == ST_BUSY) begin
               w_dev_read_req_nxt   = r_dir_rd;
               w_dev_write_req_nxt  = !r_dir_rd;
               w_dev_read_addr_nxt  = r_dir_rd ? r_addr : '0;
               w_dev_write_addr_nxt = r_dir_rd ? '0 : r_addr;
               w_dev_wdata_nxt      = r_wdata;
            end else begin
               w_ch_read_ack_nxt  = r_dir_rd ? w_gnt_mask : '0;
               w_ch_write_ack_nxt = r_dir_rd ? '0 : w_gnt_mask;
               w_ch_err_nxt       = w_dev_ack ? '0 : w_gnt_mask;
               w_ch_rdata_nxt     = !r_dir_rd ? '0 : (w_dev_ack ? dev_rdata_i : '1);
            end
         end
         ST_RESP: w_ch_rdata_nxt = r_ch_rdata;
         default: w_ch_rdata_nxt = r_ch_rdata;
      endcase
   end

   // Output registers; async reset clears every output immediately.
   always_ff @(posedge clk or negedge reset_n_i) begin
      if (!reset_n_i) begin
         r_dev_read_req   <= 1'b0;
         r_dev_write_req  <= 1'b0;
         r_dev_read_addr  <= '0;
         r_dev_write_addr <= '0;
         r_dev_wdata      <= '0;
         r_ch_read_ack    <= '0;
         r_ch_write_ack   <= '0;
         r_ch_err         <= '0;
         r_ch_rdata       <= '0;
      end else begin
         r_dev_read_req   <= w_dev_read_req_nxt;
         r_dev_write_req  <= w_dev_write_req_nxt;
         r_dev_read_addr  <= w_dev_read_addr_nxt;
         r_dev_write_addr <= w_dev_write_addr_nxt;
         r_dev_wdata      <= w_dev_wdata_nxt;
         r_ch_read_ack    <= w_ch_read_ack_nxt;
         r_ch_write_ack   <= w_ch_write_ack_nxt;
         r_ch_err         <= w_ch_err_nxt;
         r_ch_rdata       <= w_ch_rdata_nxt;
      end
   end

   assign dev_read_req_o   = r_dev_read_req;
   assign dev_write_req_o  = r_dev_write_req;
   assign dev_read_addr_o  = r_dev_read_addr;
   assign dev_write_addr_o = r_dev_write_addr;
   assign dev_wdata_o      = r_dev_wdata;
   assign ch_read_ack_o    = r_ch_read_ack;
   assign ch_write_ack_o   = r_ch_write_ack;
   assign ch_err_o         = r_ch_err;
   assign ch_rdata_o       = r_ch_rdata;

endmodule
